// File: rtl/glyph_field_renderer_pkg.sv
// Shared constants and commit-FSM encoding for the glyph field renderer.
package glyph_field_renderer_pkg;

  localparam int         GLYPH_W    = 16;
  localparam int         GLYPH_H    = 32;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         RGB_W      = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COPY    = 2'd2
  } commit_state_e;

endpackage

// File: rtl/glyph_field_renderer_slot_bank.sv
// Shadow/display slot register pair: the writer fills the shadow bank,
// a copy strobe publishes the whole bank to the display side at once.
module glyph_slot_bank
  import glyph_field_renderer_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_slot,
  input  logic [3:0] wr_code,
  input  logic       copy,
  input  logic [2:0] rd_slot,
  output logic [3:0] rd_code
);

  localparam logic [3:0] SLOT_LIM = 4'(NUM_SLOTS);

  logic [7:0][3:0] shadow_q, shadow_d;
  logic [7:0][3:0] display_q, display_d;

  always_comb begin
    shadow_d  = shadow_q;
    display_d = display_q;
    // Out-of-range slots are accepted by the handshake but dropped here.
    if (wr_en && ({1'b0, wr_slot} < SLOT_LIM)) begin
      shadow_d[wr_slot] = wr_code;
    end
    if (copy) begin
      display_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= {8{BLANK_CODE}};
      display_q <= {8{BLANK_CODE}};
    end else begin
      shadow_q  <= shadow_d;
      display_q <= display_d;
    end
  end

  assign rd_code = display_q[rd_slot];

endmodule

// File: rtl/glyph_field_renderer.sv
// Maps the VGA pixel position onto a row of 16x32 glyph slots, drives the glyph ROM
// and returns the pixel colour two pixel ticks later, with a blinking edit cursor.
module glyph_field_renderer
  import glyph_field_renderer_pkg::*;
#(
  parameter int         ORIGIN_X     = 192,
  parameter int         ORIGIN_Y     = 224,
  parameter int         NUM_SLOTS    = 8,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_slot,
  input  logic [3:0]  wr_code,
  input  logic        commit,
  output logic        busy,
  input  logic        cursor_en,
  input  logic [2:0]  cursor_slot,
  output logic [3:0]  glyph_sel,
  output logic [4:0]  glyph_row,
  output logic [3:0]  glyph_col,
  input  logic [11:0] rom_pixel,
  output logic [11:0] rgb,
  output logic        rgb_valid
);

  localparam logic [9:0] ORG_X      = 10'(ORIGIN_X);
  localparam logic [9:0] ORG_Y      = 10'(ORIGIN_Y);
  localparam logic [9:0] FIELD_W    = 10'(NUM_SLOTS * GLYPH_W);
  localparam logic [9:0] FIELD_H    = 10'(GLYPH_H);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  commit_state_e    state_q, state_d;
  logic             copy_en;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic [9:0]       dx, dy;
  logic [2:0]       slot;
  logic [3:0]       slot_code;
  logic             in_field, blank;

  logic [3:0]       glyph_sel_q, glyph_sel_d;
  logic [4:0]       glyph_row_q, glyph_row_d;
  logic [3:0]       glyph_col_q, glyph_col_d;
  logic             in_field_q, in_field_d;
  logic             video_on_q, video_on_d;
  logic             blank_q, blank_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             rgb_valid_q, rgb_valid_d;

  assign wr_ready = (state_q != ST_COPY);
  assign busy     = (state_q != ST_IDLE);

  glyph_slot_bank #(.NUM_SLOTS(NUM_SLOTS)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_valid & wr_ready),
    .wr_slot (wr_slot),
    .wr_code (wr_code),
    .copy    (copy_en),
    .rd_slot (slot),
    .rd_code (slot_code)
  );

  // Commit arriving together with frame_start only arms; the copy waits a full frame.
  always_comb begin
    state_d = state_q;
    copy_en = 1'b0;
    case (state_q)
      ST_IDLE:    if (commit) state_d = ST_PENDING;
      ST_PENDING: if (frame_start) state_d = ST_COPY;
      ST_COPY: begin
        copy_en = 1'b1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!cursor_en) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (frame_start) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Unsigned subtraction plus the >= origin test clips the field without wrap-around.
  always_comb begin
    dx       = pixel_x - ORG_X;
    dy       = pixel_y - ORG_Y;
    slot     = dx[6:4];
    in_field = (pixel_x >= ORG_X) & (dx < FIELD_W) & (pixel_y >= ORG_Y) & (dy < FIELD_H);
    blank    = (slot_code == BLANK_CODE) |
               (cursor_en & blink_phase_q & (slot == cursor_slot));
  end

  always_comb begin
    glyph_sel_d = glyph_sel_q;
    glyph_row_d = glyph_row_q;
    glyph_col_d = glyph_col_q;
    in_field_d  = in_field_q;
    video_on_d  = video_on_q;
    blank_d     = blank_q;
    rgb_d       = rgb_q;
    rgb_valid_d = rgb_valid_q;
    if (pixel_tick) begin
      glyph_sel_d = slot_code;
      glyph_row_d = dy[4:0];
      glyph_col_d = dx[3:0];
      in_field_d  = in_field;
      video_on_d  = video_on;
      blank_d     = blank;
      if (!video_on_q)                rgb_d = '0;
      else if (in_field_q && !blank_q) rgb_d = rom_pixel;
      else                            rgb_d = BG_COLOR;
      rgb_valid_d = video_on_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      glyph_sel_q   <= '0;
      glyph_row_q   <= '0;
      glyph_col_q   <= '0;
      in_field_q    <= 1'b0;
      video_on_q    <= 1'b0;
      blank_q       <= 1'b0;
      rgb_q         <= '0;
      rgb_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      glyph_sel_q   <= glyph_sel_d;
      glyph_row_q   <= glyph_row_d;
      glyph_col_q   <= glyph_col_d;
      in_field_q    <= in_field_d;
      video_on_q    <= video_on_d;
      blank_q       <= blank_d;
      rgb_q         <= rgb_d;
      rgb_valid_q   <= rgb_valid_d;
    end
  end

  assign glyph_sel = glyph_sel_q;
  assign glyph_row = glyph_row_q;
  assign glyph_col = glyph_col_q;
  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_glyph_field_renderer.sv
// Randomized bench for glyph_field_renderer against a behavioural model of slots, commit and blink.
module tb_glyph_field_renderer;

  localparam int          OX = 192;
  localparam int          OY = 224;
  localparam int          BF = 2;
  localparam logic [11:0] BG = 12'h0A5;

  logic        clk = 1'b0;
  logic        reset, pixel_tick, video_on, frame_start, wr_valid, wr_ready;
  logic [9:0]  pixel_x, pixel_y;
  logic [2:0]  wr_slot, cursor_slot;
  logic [3:0]  wr_code, glyph_sel, glyph_col;
  logic [4:0]  glyph_row;
  logic        commit, busy, cursor_en, rgb_valid;
  logic [11:0] rom_pixel, rgb;

  always #5 clk = ~clk;

  // Glyph ROM stand-in: a colour that encodes code, column and row.
  assign rom_pixel = {~glyph_sel, glyph_col, glyph_row[3:0]};

  glyph_field_renderer #(
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .NUM_SLOTS(8), .BLINK_FRAMES(BF), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_slot(wr_slot), .wr_code(wr_code), .commit(commit), .busy(busy),
    .cursor_en(cursor_en), .cursor_slot(cursor_slot), .glyph_sel(glyph_sel),
    .glyph_row(glyph_row), .glyph_col(glyph_col), .rom_pixel(rom_pixel),
    .rgb(rgb), .rgb_valid(rgb_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  int   m_shadow[8];
  int   m_disp[8];
  bit   m_pend;
  int   m_cnt;
  bit   m_phase;
  bit   m_cen;
  int   m_cslot;
  logic [11:0] prev_rgb;
  bit   prev_von;
  bit   have_prev;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rom_model(input int code, input int row, input int col);
    logic [3:0] c, r, k;
    c = code[3:0];
    r = row[3:0];
    k = col[3:0];
    return {~c, k, r};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 15;
      m_disp[i]   = 15;
    end
    m_pend = 0; m_cnt = 0; m_phase = 0; have_prev = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic blink_update();
    if (m_cen) begin
      if (m_cnt == BF - 1) begin
        m_cnt = 0;
        m_phase = !m_phase;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic px(input int x, input int y, input bit von);
    int dx, dy, slot, code;
    bit inf, blk;
    logic [11:0] exp;
    dx   = (x - OX) & 1023;
    dy   = (y - OY) & 1023;
    inf  = (x >= OX) && (dx < 128) && (y >= OY) && (dy < 32);
    slot = (dx >> 4) & 7;
    code = m_disp[slot];
    blk  = (code == 15) || (m_cen && m_phase && slot == m_cslot);
    if (!von)              exp = 12'h000;
    else if (inf && !blk)  exp = rom_model(code, dy & 31, dx & 15);
    else                   exp = BG;
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    check_val("glyph_col", 32'(glyph_col), 32'(dx & 15));
    check_val("glyph_row", 32'(glyph_row), 32'(dy & 31));
    check_val("glyph_sel", 32'(glyph_sel), 32'(code));
    if (have_prev) begin
      check_val("rgb", 32'(rgb), 32'(prev_rgb));
      check_val("rgb_valid", 32'(rgb_valid), 32'(prev_von));
    end
    prev_rgb = exp; prev_von = von; have_prev = 1;
    repeat ($urandom_range(0, 2)) begin
      pixel_x = 10'($urandom);
      step();
    end
  endtask

  task automatic scan_rand(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
      end else begin
        x = $urandom_range(OX - 20, OX + 150); y = $urandom_range(OY - 4, OY + 36);
      end
      px(x, y, $urandom_range(0, 5) != 0);
    end
  endtask

  task automatic wr(input int slot, input int code);
    wr_valid = 1'b1; wr_slot = 3'(slot); wr_code = 4'(code);
    step();
    wr_valid = 1'b0;
    m_shadow[slot] = code;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
    if (!m_pend) m_pend = 1;
    check_val("busy_pending", 32'(busy), 32'd1);
  endtask

  task automatic do_frame_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    blink_update();
    if (m_pend) begin
      check_val("wr_ready_copy", 32'(wr_ready), 32'd0);
      check_val("busy_copy", 32'(busy), 32'd1);
      step();
      m_disp = m_shadow;
      m_pend = 0;
    end
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("wr_ready_idle", 32'(wr_ready), 32'd1);
  endtask

  task automatic set_cursor(input bit en, input int slot);
    cursor_en = en; cursor_slot = 3'(slot);
    step();
    m_cen = en; m_cslot = slot;
    if (!en) begin
      m_cnt = 0; m_phase = 0;
    end
  endtask

  task automatic boundaries();
    px(OX - 1, OY + 3, 1);
    px(OX, OY, 1);
    px(OX + 127, OY + 31, 1);
    px(OX + 128, OY + 5, 1);
    px(OX + 60, OY + 32, 1);
    px(OX + 60, OY - 1, 1);
    px(OX + 5, OY + 7, 1);
    px(0, 0, 0);
  endtask

  initial begin
    int codes[8] = '{1, 2, 15, 3, 4, 15, 5, 6};
    reset = 1'b1; pixel_tick = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    frame_start = 1'b0; wr_valid = 1'b0; wr_slot = '0; wr_code = '0; commit = 1'b0;
    cursor_en = 1'b0; cursor_slot = '0;
    m_cen = 0; m_cslot = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check_val("rst_rgb", 32'(rgb), 32'd0);
    check_val("rst_rgb_valid", 32'(rgb_valid), 32'd0);
    check_val("rst_glyph_sel", 32'(glyph_sel), 32'd0);
    check_val("rst_glyph_row", 32'(glyph_row), 32'd0);
    check_val("rst_glyph_col", 32'(glyph_col), 32'd0);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);

    // Blank display: BG in active video, 0 outside it.
    boundaries();
    scan_rand(120);
    check_val("busy_after_scan", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) wr(i, codes[i]);
    do_commit();
    do_frame_start();
    do_frame_start();
    boundaries();
    scan_rand(60);

    // Commit timing: display holds until frame_start; write held through COPY lands later.
    wr(0, 2);
    do_commit();
    px(OX + 3, OY + 10, 1);
    px(OX + 20, OY + 10, 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    blink_update();
    check_val("wr_ready_copy", 32'(wr_ready), 32'd0);
    check_val("busy_copy", 32'(busy), 32'd1);
    wr_valid = 1'b1; wr_slot = 3'd1; wr_code = 4'd7;
    step();
    m_disp = m_shadow; m_pend = 0;
    check_val("busy_after_copy", 32'(busy), 32'd0);
    check_val("wr_ready_after_copy", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    m_shadow[1] = 7;
    px(OX + 3, OY + 10, 1);
    px(OX + 20, OY + 10, 1);
    px(OX + 21, OY + 11, 1);

    // commit together with frame_start only arms the copy.
    commit = 1'b1; frame_start = 1'b1;
    step();
    commit = 1'b0; frame_start = 1'b0;
    blink_update();
    m_pend = 1;
    check_val("busy_armed", 32'(busy), 32'd1);
    px(OX + 20, OY + 10, 1);
    px(OX + 22, OY + 12, 1);
    do_frame_start();
    px(OX + 20, OY + 10, 1);
    px(OX + 23, OY + 13, 1);

    // Cursor blink on slot 3.
    set_cursor(1, 3);
    for (int f = 0; f < 8; f++) begin
      do_frame_start();
      px(OX + 48 + f, OY + 4, 1);
      px(OX + 32 + f, OY + 4, 1);
      px(OX + 64 + f, OY + 4, 1);
      px(OX + 50, OY + 9 + f, 1);
    end
    set_cursor(0, 0);
    px(OX + 50, OY + 9, 1);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1: wr($urandom_range(0, 7), $urandom_range(0, 15));
        2: do_commit();
        3: do_frame_start();
        4: set_cursor($urandom_range(0, 1) == 1, $urandom_range(0, 7));
        default: scan_rand(6);
      endcase
    end
    if (m_pend) do_frame_start();
    scan_rand(20);

    // Reset while a commit is pending loses it and blanks both banks.
    wr(2, 9);
    do_commit();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_wr_ready", 32'(wr_ready), 32'd1);
    do_frame_start();
    px(OX + 40, OY + 8, 1);
    boundaries();
    scan_rand(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
